// File: rtl/alu16_op_sequencer.sv
// alu16_op_sequencer: sequences one ALU operation (A, B, S loads over the shared T bus) per request and returns F/flags; optional SEQ_SKIP_B_EN skips the B load for unary opcodes
module alu16_op_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_t,
   output logic [1:0]       alu_m,
   input  logic [WIDTH:0]   alu_f,
   input  logic             alu_c,
   input  logic             alu_z,
   input  logic             alu_n,
   input  logic             alu_ov,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH:0]   rsp_f,
   output logic             rsp_c,
   output logic             rsp_z,
   output logic             rsp_n,
   output logic             rsp_ov,
   output logic             rsp_illegal,
   output logic             busy
);
   typedef enum logic [2:0] {IDLE, LDA, LDB, LDS, S_WAIT, RESP} state_t;
   state_t state, state_nx;
   logic [3:0] op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic unary;
`ifdef SEQ_SKIP_B_EN
   assign unary = op_q == 4'd3 || op_q == 4'd4 || (op_q >= 4'd7 && op_q <= 4'd11);
`else
   assign unary = 1'b0;
`endif
   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   assign busy      = state != IDLE;
   // state register; reset abandons any operation in flight
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   // next state and T/M drive; M rests at 10 outside the three load states
   always_comb begin
      state_nx = state;
      alu_m    = 2'b10;
      alu_t    = '0;
      case (state)
         IDLE:    state_nx = req_valid ? LDA : IDLE;
         LDA: begin
            alu_m    = 2'b00;
            alu_t    = a_q;
            state_nx = unary ? LDS : LDB;
         end
         LDB: begin
            alu_m    = 2'b01;
            alu_t    = b_q;
            state_nx = LDS;
         end
         LDS: begin
            alu_m    = 2'b11;
            alu_t    = {{(WIDTH-4){1'b0}}, op_q};
            state_nx = S_WAIT;
         end
         S_WAIT:  state_nx = RESP;
         RESP:    state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   // request latch on accept, response capture on leaving the settle cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_f       <= '0;
         rsp_c       <= 1'b0;
         rsp_z       <= 1'b0;
         rsp_n       <= 1'b0;
         rsp_ov      <= 1'b0;
         rsp_illegal <= 1'b0;
      end else if (state == IDLE && req_valid) begin
         op_q <= req_op;
         a_q  <= req_a;
         b_q  <= req_b;
      end else if (state == S_WAIT) begin
         rsp_f       <= alu_f;
         rsp_c       <= alu_c;
         rsp_z       <= alu_z;
         rsp_n       <= alu_n;
         rsp_ov      <= alu_ov;
         rsp_illegal <= op_q == 4'd0 || op_q > 4'd11;
      end
endmodule

// File: tb/tb_alu16_op_sequencer.sv
// tb_alu16_op_sequencer: table-driven check of the ALU op sequencer against a small ALU stand-in
module tb_alu16_op_sequencer;
   logic clk = 1'b0, rst = 1'b0;
   logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, busy;
   logic [3:0] req_op = '0;
   logic [15:0] req_a = '0, req_b = '0, alu_t;
   logic [1:0] alu_m;
   logic [16:0] alu_f, rsp_f;
   logic alu_c, alu_z, alu_n, alu_ov, rsp_c, rsp_z, rsp_n, rsp_ov, rsp_illegal;
   int checks = 0, errors = 0;
`ifdef SEQ_SKIP_B_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   alu16_op_sequencer #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .alu_t(alu_t), .alu_m(alu_m), .alu_f(alu_f),
      .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_ov(alu_ov), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_n(rsp_n),
      .rsp_ov(rsp_ov), .rsp_illegal(rsp_illegal), .busy(busy));
   always #5 clk = ~clk;
   // ALU stand-in: registers loaded through T/M, F as a 17-bit signed result
   logic [15:0] ra = '0, rb = '0;
   logic [3:0] rs = '0;
   always @(posedge clk) begin
      if (alu_m == 2'b00) ra <= alu_t;
      if (alu_m == 2'b01) rb <= alu_t;
      if (alu_m == 2'b11) rs <= alu_t[3:0];
   end
   always_comb begin
      logic [16:0] sum;
      sum   = {1'b0, ra} + {1'b0, rb};
      alu_f = '0;
      alu_c = 1'b0;
      case (rs)
         4'd1: begin alu_f = {ra[15], ra} + {rb[15], rb}; alu_c = sum[16]; end
         4'd2: begin alu_f = {ra[15], ra} - {rb[15], rb}; alu_c = ra >= rb; end
         4'd3: begin alu_f = {ra[15], ra} + 17'd1; alu_c = ra == 16'hFFFF; end
         default: ;
      endcase
      alu_z  = alu_f == '0;
      alu_n  = alu_f[16];
      alu_ov = alu_f[16] ^ alu_f[15];
   end
   typedef struct {
      logic [3:0] op;
      logic [15:0] a, b;
      logic [16:0] f;
      logic c, z, n, ov, ill;
   } vec_t;
   vec_t vt[9];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic bit is_unary(input logic [3:0] op);
      return op == 4'd3 || op == 4'd4 || (op >= 4'd7 && op <= 4'd11);
   endfunction
   task automatic run(input int i, input int hold);
      vec_t v;
      bit sk;
      v  = vt[i];
      sk = SKIP && is_unary(v.op);
      req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
      rsp_ready = hold == 0;
      chk("req_ready_idle", req_ready, 1);
      step();
      req_valid = 1'b0; req_op = 4'd5; req_a = 16'hDEAD; req_b = 16'hBEEF;
      chk("m_lda", alu_m, 2'b00);
      chk("t_lda", alu_t, v.a);
      chk("busy_lda", {busy, req_ready}, 2'b10);
      step();
      if (!sk) begin
         chk("m_ldb", alu_m, 2'b01);
         chk("t_ldb", alu_t, v.b);
         step();
      end
      chk("m_lds", alu_m, 2'b11);
      chk("t_lds", alu_t, {12'd0, v.op});
      step();
      chk("m_wait", {alu_m, alu_t}, {2'b10, 16'd0});
      chk("valid_wait", rsp_valid, 0);
      step();
      chk("valid_resp", rsp_valid, 1);
      chk("rsp_f", rsp_f, v.f);
      chk("rsp_flags", {rsp_c, rsp_z, rsp_n, rsp_ov, rsp_illegal}, {v.c, v.z, v.n, v.ov, v.ill});
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1; req_op = 4'd1;
         step();
         chk("stall_valid", {rsp_valid, req_ready}, 2'b10);
         chk("stall_f", rsp_f, v.f);
         chk("stall_flags", {rsp_c, rsp_z, rsp_n, rsp_ov, rsp_illegal}, {v.c, v.z, v.n, v.ov, v.ill});
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      step();
      chk("post_valid", {rsp_valid, req_ready, busy}, 3'b010);
      chk("post_f_hold", rsp_f, v.f);
      chk("post_m", alu_m, 2'b10);
   endtask
   initial begin
      vt[0] = '{4'd1,  16'h7FFF, 16'h0001, 17'h08000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[1] = '{4'd2,  16'h0005, 16'h0005, 17'h00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2] = '{4'd3,  16'hFFFF, 16'h1234, 17'h00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[3] = '{4'd0,  16'h1234, 16'h0001, 17'h00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[4] = '{4'd1,  16'h8000, 16'h8000, 17'h10000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[5] = '{4'd2,  16'h0003, 16'h0005, 17'h1FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[6] = '{4'd12, 16'h00AA, 16'h0055, 17'h00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[7] = '{4'd3,  16'h7FFF, 16'hFFFF, 17'h08000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[8] = '{4'd11, 16'h0F0F, 16'h0001, 17'h00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      #2 rst = 1'b1;
      #1;
      chk("rst_m_t", {alu_m, alu_t}, {2'b10, 16'd0});
      chk("rst_rsp", {rsp_valid, rsp_f, rsp_c, rsp_z, rsp_n, rsp_ov, rsp_illegal, busy}, '0);
      step();
      rst = 1'b0;
      chk("idle_ready", {req_ready, busy}, 2'b10);
      for (int i = 0; i < 9; i++) run(i, 0);
      run(0, 10);
      req_valid = 1'b1; req_op = 4'd1; req_a = 16'h0001; req_b = 16'h0002; rsp_ready = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      chk("pre_rst_ldb", alu_m, 2'b01);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_m", alu_m, 2'b10);
      chk("rst_mid_valid", {rsp_valid, busy}, 2'b00);
      step();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("no_rsp_after_rst", {rsp_valid, busy, alu_m}, {2'b00, 2'b10});
      end
      run(1, 0);
      run(4, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
